// File: rtl/riscv_dmem_arbiter.sv
// Two-port data-memory arbiter: CPU port A (byte/half/word, aligned only) and
// debug/DMA port B (word), sharing one synchronous single-port RAM.
module riscv_dmem_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int B_MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_unsigned,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic              a_err,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic {A_PRIO, B_PRIO} arb_state_t;

  arb_state_t  state, state_next;
  logic [2:0]  burst_cnt, burst_cnt_next;
  logic        burst_done;
  logic        grant_a, grant_b;
  logic        a_misaligned;

  logic        rd_valid;
  logic        rd_owner_b;
  logic [1:0]  rd_off;
  logic [1:0]  rd_size;
  logic        rd_unsigned;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] a_rdata_q, b_rdata_q;

  logic        addr_unused;
  assign addr_unused = ^a_addr[31:ADDR_W+2];

  assign burst_done = (burst_cnt >= 3'(B_MAX_BURST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= A_PRIO;
      burst_cnt <= 3'd0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  // The burst counter saturates so a long B stream cannot wrap it while A is idle.
  always_comb begin
    state_next     = state;
    burst_cnt_next = burst_cnt;
    grant_a        = 1'b0;
    grant_b        = 1'b0;
    case (state)
      A_PRIO: begin
        if (a_req) begin
          grant_a = 1'b1;
        end else if (b_req) begin
          grant_b        = 1'b1;
          state_next     = B_PRIO;
          burst_cnt_next = 3'd1;
        end
      end
      B_PRIO: begin
        if (!b_req) begin
          grant_a        = a_req;
          state_next     = A_PRIO;
          burst_cnt_next = 3'd0;
        end else if (a_req && burst_done) begin
          grant_a        = 1'b1;
          state_next     = A_PRIO;
          burst_cnt_next = 3'd0;
        end else begin
          grant_b = 1'b1;
          if (!burst_done) begin
            burst_cnt_next = burst_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_next     = A_PRIO;
        burst_cnt_next = 3'd0;
      end
    endcase
    if (!rst) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  assign a_gnt = grant_a;
  assign b_gnt = grant_b;

  always_comb begin
    case (a_size)
      2'b00:   a_misaligned = 1'b0;
      2'b01:   a_misaligned = a_addr[0];
      2'b10:   a_misaligned = |a_addr[1:0];
      default: a_misaligned = 1'b1;
    endcase
  end

  // Store data is replicated across lanes; only the enabled lanes are written.
  always_comb begin
    ram_we   = 4'b0000;
    ram_addr = '0;
    ram_din  = 32'h0;
    if (grant_a) begin
      ram_addr = a_addr[ADDR_W+1:2];
      if (a_we && !a_misaligned) begin
        case (a_size)
          2'b00: begin
            ram_we  = 4'b0001 << a_addr[1:0];
            ram_din = {4{a_wdata[7:0]}};
          end
          2'b01: begin
            ram_we  = 4'b0011 << a_addr[1:0];
            ram_din = {2{a_wdata[15:0]}};
          end
          default: begin
            ram_we  = 4'b1111;
            ram_din = a_wdata;
          end
        endcase
      end
    end else if (grant_b) begin
      ram_addr = b_addr;
      ram_din  = b_wdata;
      if (b_we) begin
        ram_we = 4'b1111;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid    <= 1'b0;
      rd_owner_b  <= 1'b0;
      rd_off      <= 2'b00;
      rd_size     <= 2'b00;
      rd_unsigned <= 1'b0;
      a_err       <= 1'b0;
      a_rdata_q   <= 32'h0;
      b_rdata_q   <= 32'h0;
    end else begin
      rd_valid    <= (grant_a && !a_we && !a_misaligned) || (grant_b && !b_we);
      rd_owner_b  <= grant_b;
      rd_off      <= a_addr[1:0];
      rd_size     <= a_size;
      rd_unsigned <= a_unsigned;
      a_err       <= grant_a && a_misaligned;
      a_rdata_q   <= a_rdata;
      b_rdata_q   <= b_rdata;
    end
  end

  always_comb begin
    rd_byte = ram_dout[{rd_off, 3'b000} +: 8];
    rd_half = rd_off[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (rd_size)
      2'b00:   load_data = {{24{~rd_unsigned & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{~rd_unsigned & rd_half[15]}}, rd_half};
      default: load_data = ram_dout;
    endcase
  end

  assign a_rvalid = rd_valid & ~rd_owner_b;
  assign b_rvalid = rd_valid &  rd_owner_b;
  assign a_rdata  = a_rvalid ? load_data : a_rdata_q;
  assign b_rdata  = b_rvalid ? ram_dout  : b_rdata_q;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model with its own word memory.
module tb_riscv_dmem_arbiter;

  localparam int ADDR_W = 14;
  localparam int B_MAX  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_req, a_we, a_unsigned;
  logic [1:0]        a_size;
  logic [31:0]       a_addr, a_wdata;
  logic              a_gnt, a_rvalid, a_err;
  logic [31:0]       a_rdata;
  logic              b_req, b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [31:0]       b_wdata;
  logic              b_gnt, b_rvalid;
  logic [31:0]       b_rdata;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din, ram_dout;

  int tests_run    = 0;
  int tests_failed = 0;

  bit [31:0] ram_mem [0:15];
  bit [31:0] ref_mem [0:15];

  bit          m_b_prio;
  int          m_run;
  bit          exp_a_rvalid, exp_b_rvalid, exp_a_err;
  logic [31:0] exp_a_rdata, exp_b_rdata;

  logic        s_a_gnt, s_b_gnt, s_a_rvalid, s_b_rvalid, s_a_err;
  logic [3:0]  s_ram_we;
  logic [31:0] s_ram_addr, s_ram_din, s_a_rdata, s_b_rdata;
  bit          last_ga, last_gb;
  int          b_grants;

  riscv_dmem_arbiter #(.ADDR_W(ADDR_W), .B_MAX_BURST(B_MAX)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_unsigned(a_unsigned),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: byte-lane writes, read data one cycle after the address.
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (ram_we[l]) ram_mem[ram_addr[3:0]][8*l +: 8] <= ram_din[8*l +: 8];
    ram_dout <= ram_mem[ram_addr[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [31:0] word, input int off,
                                             input int size, input bit uns);
    int unsigned v;
    if (size == 0) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (word >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_b_prio     = 1'b0;
    m_run        = 0;
    exp_a_rvalid = 1'b0;
    exp_b_rvalid = 1'b0;
    exp_a_err    = 1'b0;
    exp_a_rdata  = 32'h0;
    exp_b_rdata  = 32'h0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_a_gnt"}, a_gnt, 0);
    check({pfx, "_b_gnt"}, b_gnt, 0);
    check({pfx, "_a_rvalid"}, a_rvalid, 0);
    check({pfx, "_b_rvalid"}, b_rvalid, 0);
    check({pfx, "_a_err"}, a_err, 0);
    check({pfx, "_ram_we"}, ram_we, 0);
    check({pfx, "_a_rdata"}, a_rdata, 0);
    check({pfx, "_b_rdata"}, b_rdata, 0);
  endtask

  // Requests are presented while reset is low to show the grants stay masked.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; a_size = 2'd2;
    a_addr = 32'h0; b_we = 1'b0; b_addr = '0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    model_reset();
  endtask

  // One clock of traffic: predict, sample at negedge, then advance the model.
  task automatic run_cycle();
    bit          ga, gb, mis;
    logic [3:0]  we_e;
    logic [31:0] din_e, mask;
    int          off, wi, idx;
    @(negedge clk);
    ga = 1'b0; gb = 1'b0;
    if (!m_b_prio) begin
      ga = a_req;
      gb = !a_req && b_req;
    end else if (!b_req) begin
      ga = a_req;
    end else if (a_req && m_run >= B_MAX) begin
      ga = 1'b1;
    end else begin
      gb = 1'b1;
    end
    off = int'(a_addr[1:0]);
    wi  = int'(a_addr[5:2]);
    mis = (a_size == 2'd3) || (a_size == 2'd1 && off % 2 == 1) || (a_size == 2'd2 && off != 0);
    we_e = 4'b0; din_e = 32'h0;
    if (ga && a_we && !mis) begin
      if (a_size == 2'd0) begin
        we_e = 4'(1 << off); din_e = 32'(a_wdata[7:0]) << (8 * off);
      end else if (a_size == 2'd1) begin
        we_e = 4'(3 << off); din_e = 32'(a_wdata[15:0]) << (8 * off);
      end else begin
        we_e = 4'hF; din_e = a_wdata;
      end
    end
    if (gb && b_we) begin
      we_e = 4'hF; din_e = b_wdata;
    end
    mask = {{8{we_e[3]}}, {8{we_e[2]}}, {8{we_e[1]}}, {8{we_e[0]}}};

    s_a_gnt = a_gnt; s_b_gnt = b_gnt; s_ram_we = ram_we;
    s_ram_addr = 32'(ram_addr); s_ram_din = ram_din;
    s_a_rvalid = a_rvalid; s_b_rvalid = b_rvalid; s_a_err = a_err;
    s_a_rdata = a_rdata; s_b_rdata = b_rdata;

    check("a_gnt", s_a_gnt, ga);
    check("b_gnt", s_b_gnt, gb);
    check("ram_we", s_ram_we, we_e);
    if (ga) check("ram_addr_a", s_ram_addr, (a_addr >> 2) & ((32'd1 << ADDR_W) - 1));
    if (gb) check("ram_addr_b", s_ram_addr, 32'(b_addr));
    if (we_e != 4'b0) check("ram_din", s_ram_din & mask, din_e & mask);
    check("a_rvalid", s_a_rvalid, exp_a_rvalid);
    check("b_rvalid", s_b_rvalid, exp_b_rvalid);
    check("a_err", s_a_err, exp_a_err);
    check("a_rdata", s_a_rdata, exp_a_rdata);
    check("b_rdata", s_b_rdata, exp_b_rdata);
    last_ga = ga; last_gb = gb;

    @(posedge clk); #1;
    exp_a_rvalid = ga && !a_we && !mis;
    exp_b_rvalid = gb && !b_we;
    exp_a_err    = ga && mis;
    if (exp_a_rvalid) exp_a_rdata = load_value(ref_mem[wi], off, int'(a_size), a_unsigned);
    if (exp_b_rvalid) exp_b_rdata = ref_mem[b_addr[3:0]];
    if (we_e != 4'b0) begin
      idx = ga ? wi : int'(b_addr[3:0]);
      for (int l = 0; l < 4; l++)
        if (we_e[l]) ref_mem[idx][8*l +: 8] = din_e[8*l +: 8];
    end
    if (!m_b_prio) begin
      if (!a_req && b_req) begin
        m_b_prio = 1'b1; m_run = 1;
      end
    end else if (!b_req || ga) begin
      m_b_prio = 1'b0; m_run = 0;
    end else if (m_run < B_MAX) begin
      m_run++;
    end
  endtask

  initial begin
    rst = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_size = 2'd0; a_unsigned = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = 32'h0;
    model_reset();
    do_reset();

    // Byte store into lane 2 of word 1.
    a_req = 1'b1; a_we = 1'b1; a_size = 2'd0; a_addr = 32'h6; a_wdata = 32'hAB;
    run_cycle();
    check("sb_ram_we", s_ram_we, 4'b0100);
    check("sb_ram_addr", s_ram_addr, 1);
    check("sb_ram_din_lane2", s_ram_din[23:16], 8'hAB);

    // Signed and unsigned halfword loads from the upper half of 0x8001_0000.
    a_we = 1'b0; a_size = 2'd2; a_addr = 32'h0;
    a_we = 1'b1; a_wdata = 32'h8001_0000;
    run_cycle();
    a_we = 1'b0; a_size = 2'd1; a_unsigned = 1'b0; a_addr = 32'h2;
    run_cycle();
    a_req = 1'b0;
    run_cycle();
    check("lh_rvalid", s_a_rvalid, 1);
    check("lh_rdata", s_a_rdata, 32'hFFFF_8001);
    a_req = 1'b1; a_unsigned = 1'b1;
    run_cycle();
    a_req = 1'b0;
    run_cycle();
    check("lhu_rvalid", s_a_rvalid, 1);
    check("lhu_rdata", s_a_rdata, 32'h0000_8001);
    run_cycle();
    check("lhu_hold", s_a_rdata, 32'h0000_8001);

    // Both ports requesting from reset: A wins every cycle.
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_unsigned = 1'b0; a_addr = 32'h4;
    b_req = 1'b1; b_we = 1'b0; b_addr = ADDR_W'(2);
    for (int k = 0; k < 5; k++) begin
      a_addr = 32'(4 * k);
      run_cycle();
      check("both_a_gnt", s_a_gnt, 1);
      check("both_b_gnt", s_b_gnt, 0);
    end

    // B burst capped once A starts requesting.
    do_reset();
    b_req = 1'b1; b_we = 1'b0; b_addr = ADDR_W'(3);
    run_cycle();
    check("burst_first_b", s_b_gnt, 1);
    b_grants = 1;
    a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_addr = 32'h4;
    for (int k = 0; k < 10; k++) begin
      run_cycle();
      if (s_b_gnt === 1'b1) b_grants++;
      if (s_a_gnt === 1'b1) break;
    end
    check("burst_b_count", b_grants, B_MAX);
    check("burst_then_a", s_a_gnt, 1);
    a_addr = 32'h8;
    run_cycle();
    check("burst_back_a_prio", s_a_gnt, 1);
    a_req = 1'b0; b_req = 1'b0;
    run_cycle();

    // Misaligned word load.
    a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_addr = 32'h5;
    run_cycle();
    check("lw_mis_gnt", s_a_gnt, 1);
    check("lw_mis_we", s_ram_we, 0);
    a_req = 1'b0;
    run_cycle();
    check("lw_mis_err", s_a_err, 1);
    check("lw_mis_no_rvalid", s_a_rvalid, 0);
    run_cycle();
    check("lw_mis_err_clear", s_a_err, 0);

    // Reset while a B load response is pending.
    b_req = 1'b1; b_we = 1'b0; b_addr = ADDR_W'(3);
    @(negedge clk);
    check("rst_mid_b_gnt", b_gnt, 1);
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    b_req = 1'b0; rst = 1'b1;
    model_reset();
    run_cycle();
    check("rst_mid_no_rvalid", s_b_rvalid, 0);
    run_cycle();
    check("rst_mid_no_rvalid2", s_b_rvalid, 0);

    // Random traffic honouring the hold-until-granted handshake.
    last_ga = 1'b1; last_gb = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!a_req || last_ga) begin
        a_req = ($urandom % 3) != 0;
        a_we = 1'($urandom % 2); a_size = 2'($urandom % 4); a_unsigned = 1'($urandom % 2);
        a_addr = $urandom % 64; a_wdata = $urandom;
      end
      if (!b_req || last_gb) begin
        b_req = ($urandom % 4) != 0;
        b_we = 1'($urandom % 2); b_addr = ADDR_W'($urandom % 16); b_wdata = $urandom;
      end
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
